// File: rtl/mem_arbiter.sv
// Arbiter between instruction-fetch and data ports onto a single SRAM driver request bus.
// Optional BUSY watchdog enabled by defining MEMARB_TIMEOUT_EN (parameter TIMEOUT_CYCLES).
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ready_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic [3:0]  ram_sel_o,
    input  logic        ram_ready_i,
    input  logic [31:0] ram_data_i,
    output logic        stall_req_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ram_ce_q, ram_ce_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_data_q, ram_data_d;
    logic [3:0]  ram_sel_q, ram_sel_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        busy;
    logic        timeout;

    assign busy = (state_q == IF_BUSY) || (state_q == MEM_BUSY);

`ifdef MEMARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;

    // Counter sits at zero outside BUSY, so it is already cleared on entry.
    assign cnt_d     = busy ? cnt_q + 1'b1 : '0;
    assign timeout   = busy && !ram_ready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign bus_err_d = timeout;
    assign bus_err_o = bus_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ram_ce_d    = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_sel_d   = ram_sel_q;
        if_data_d   = if_data_q;
        mem_data_d  = mem_data_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_ce_i) begin
                    state_d    = MEM_BUSY;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = mem_we_i;
                    ram_addr_d = mem_addr_i;
                    ram_data_d = mem_data_i;
                    ram_sel_d  = mem_sel_i;
                end else if (if_ce_i) begin
                    state_d    = IF_BUSY;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = if_addr_i;
                    ram_data_d = '0;
                    ram_sel_d  = '1;
                end
            end
            IF_BUSY: begin
                ram_ce_d = 1'b1;
                if (ram_ready_i || timeout) begin
                    state_d    = GAP;
                    ram_ce_d   = 1'b0;
                    if_ready_d = 1'b1;
                    if_data_d  = timeout ? '0 : ram_data_i;
                end
            end
            MEM_BUSY: begin
                ram_ce_d = 1'b1;
                if (ram_ready_i || timeout) begin
                    state_d     = GAP;
                    ram_ce_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    mem_data_d  = (timeout || ram_we_q) ? '0 : ram_data_i;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_sel_q   <= '0;
            if_data_q   <= '0;
            mem_data_q  <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_sel_q   <= ram_sel_d;
            if_data_q   <= if_data_d;
            mem_data_q  <= mem_data_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign ram_ce_o    = ram_ce_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;
    assign ram_sel_o   = ram_sel_q;
    assign if_data_o   = if_data_q;
    assign mem_data_o  = mem_data_q;
    assign if_ready_o  = if_ready_q;
    assign mem_ready_o = mem_ready_q;
    assign stall_req_o = (mem_ce_i & ~mem_ready_q) | (if_ce_i & ~if_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple SRAM-driver model of configurable latency.
// Covers the MEMARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_ce_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [3:0]  ram_sel_o;
    logic        ram_ready_i;
    logic [31:0] ram_data_i;
    logic        stall_req_o;
    logic        bus_err_o;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Driver model: ready in the lat-th enabled cycle; lat == 0 never readies.
    int unsigned lat = 2;
    logic [31:0] rdata = '0;
    int unsigned ce_cnt = 0;

    always @(posedge clk) begin
        if (ram_ce_o) ce_cnt <= ce_cnt + 1;
        else          ce_cnt <= 0;
    end

    assign ram_ready_i = ram_ce_o && (lat != 0) && (ce_cnt + 1 >= lat);
    assign ram_data_i  = rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_ce_i     (if_ce_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ready_o  (if_ready_o),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_sel_i   (mem_sel_i),
        .mem_data_o  (mem_data_o),
        .mem_ready_o (mem_ready_o),
        .ram_ce_o    (ram_ce_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_sel_o   (ram_sel_o),
        .ram_ready_i (ram_ready_i),
        .ram_data_i  (ram_data_i),
        .stall_req_o (stall_req_o),
        .bus_err_o   (bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_ram_ce", {31'd0, ram_ce_o}, 32'd0);
        chk("rst_ram_addr", ram_addr_o, 32'd0);
        chk("rst_ram_sel", {28'd0, ram_sel_o}, 32'd0);
        chk("rst_readys", {30'd0, if_ready_o, mem_ready_o}, 32'd0);
        chk("rst_datas", if_data_o | mem_data_o, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
        step();
        rst = 1'b1;
        step();

        // Fetch only, L=2
        lat = 2; rdata = 32'hDEAD_BEEF;
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
        #1 chk("f_stall_N", {31'd0, stall_req_o}, 32'd1);
        step();
        chk("f_ce_N1", {31'd0, ram_ce_o}, 32'd1);
        chk("f_addr_N1", ram_addr_o, 32'h0000_0010);
        chk("f_we_sel_N1", {27'd0, ram_we_o, ram_sel_o}, 32'h0000_000F);
        step();
        chk("f_ce_N2", {31'd0, ram_ce_o}, 32'd1);
        chk("f_rdy_N2", {31'd0, if_ready_o}, 32'd0);
        step();
        chk("f_rdy_N3", {31'd0, if_ready_o}, 32'd1);
        chk("f_data_N3", if_data_o, 32'hDEAD_BEEF);
        chk("f_ce_N3", {31'd0, ram_ce_o}, 32'd0);
        chk("f_stall_N3", {31'd0, stall_req_o}, 32'd0);
        if_ce_i = 1'b0;
        step();
        chk("f_rdy_N4", {31'd0, if_ready_o}, 32'd0);
        chk("f_hold_N4", if_data_o, 32'hDEAD_BEEF);
        step();

        // Simultaneous requests: MEM wins, IF follows after GAP
        rdata = 32'h1111_2222;
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0020;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0040_0000; mem_sel_i = 4'hF;
        step();
        chk("s_addr_N1", ram_addr_o, 32'h0040_0000);
        chk("s_stall_N1", {31'd0, stall_req_o}, 32'd1);
        step();
        step();
        chk("s_mrdy_N3", {31'd0, mem_ready_o}, 32'd1);
        chk("s_mdata_N3", mem_data_o, 32'h1111_2222);
        chk("s_irdy_N3", {31'd0, if_ready_o}, 32'd0);
        chk("s_stall_N3", {31'd0, stall_req_o}, 32'd1);
        mem_ce_i = 1'b0; rdata = 32'hCAFE_F00D;
        step();
        chk("s_ce_N4", {31'd0, ram_ce_o}, 32'd0);
        chk("s_mrdy_N4", {31'd0, mem_ready_o}, 32'd0);
        chk("s_stall_N4", {31'd0, stall_req_o}, 32'd1);
        step();
        chk("s_addr_N5", ram_addr_o, 32'h0000_0020);
        step();
        chk("s_stall_N6", {31'd0, stall_req_o}, 32'd1);
        step();
        chk("s_irdy_N7", {31'd0, if_ready_o}, 32'd1);
        chk("s_idata_N7", if_data_o, 32'hCAFE_F00D);
        chk("s_mhold_N7", mem_data_o, 32'h1111_2222);
        chk("s_stall_N7", {31'd0, stall_req_o}, 32'd0);
        if_ce_i = 1'b0;
        step();

        // Partial write, L=3, requester changes inputs mid-BUSY
        lat = 3; rdata = 32'hFFFF_FFFF;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0080;
        mem_data_i = 32'h0000_AB00; mem_sel_i = 4'b0010;
        step();
        chk("w_ctl_N1", {26'd0, ram_ce_o, ram_we_o, ram_sel_o}, 32'h0000_0032);
        chk("w_data_N1", ram_data_o, 32'h0000_AB00);
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0000_1234;
        mem_data_i = 32'h5555_5555; mem_sel_i = 4'hF;
        step();
        chk("w_addr_N2", ram_addr_o, 32'h0000_0080);
        chk("w_ctl_N2", {26'd0, ram_ce_o, ram_we_o, ram_sel_o}, 32'h0000_0032);
        step();
        chk("w_addr_N3", ram_addr_o, 32'h0000_0080);
        chk("w_ctl_N3", {26'd0, ram_ce_o, ram_we_o, ram_sel_o}, 32'h0000_0032);
        chk("w_data_N3", ram_data_o, 32'h0000_AB00);
        step();
        chk("w_mrdy_N4", {31'd0, mem_ready_o}, 32'd1);
        chk("w_mdata_N4", mem_data_o, 32'd0);
        chk("w_ce_N4", {31'd0, ram_ce_o}, 32'd0);
        chk("w_ihold_N4", if_data_o, 32'hCAFE_F00D);
        step();
        chk("w_idle_ce", {31'd0, ram_ce_o}, 32'd0);

        // Reset asserted during MEM_BUSY
        lat = 0;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0100;
        step();
        step();
        chk("r_busy_ce", {31'd0, ram_ce_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("r_ce_now", {31'd0, ram_ce_o}, 32'd0);
        chk("r_readys_now", {30'd0, if_ready_o, mem_ready_o}, 32'd0);
        mem_ce_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("r_idle_ce", {31'd0, ram_ce_o}, 32'd0);
        lat = 1; rdata = 32'h5A5A_A5A5;
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0040;
        step();
        chk("r_f_ce_N1", {31'd0, ram_ce_o}, 32'd1);
        chk("r_f_addr_N1", ram_addr_o, 32'h0000_0040);
        step();
        chk("r_f_rdy_N2", {31'd0, if_ready_o}, 32'd1);
        chk("r_f_data_N2", if_data_o, 32'h5A5A_A5A5);
        if_ce_i = 1'b0;
        step();
        step();

        // Driver never readies
        lat = 0; rdata = 32'h7777_7777;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0200;
`ifdef MEMARB_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("t_busy_ce", {30'd0, ram_ce_o, bus_err_o}, 32'd2);
            chk("t_busy_rdy", {31'd0, mem_ready_o}, 32'd0);
        end
        step();
        chk("t_rdy", {31'd0, mem_ready_o}, 32'd1);
        chk("t_err", {31'd0, bus_err_o}, 32'd1);
        chk("t_data", mem_data_o, 32'd0);
        chk("t_ce", {31'd0, ram_ce_o}, 32'd0);
        mem_ce_i = 1'b0;
        step();
        chk("t_err_clr", {30'd0, bus_err_o, mem_ready_o}, 32'd0);
`else
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("n_wait_ce", {31'd0, ram_ce_o}, 32'd1);
            chk("n_wait_rdy_err", {30'd0, mem_ready_o, bus_err_o}, 32'd0);
        end
        lat = 1;
        step();
        chk("n_done_rdy", {31'd0, mem_ready_o}, 32'd1);
        chk("n_done_data", mem_data_o, 32'h7777_7777);
        chk("n_done_err", {31'd0, bus_err_o}, 32'd0);
        mem_ce_i = 1'b0;
        step();
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly upstream of the SRAM driver.
- Arbitrates the instruction-fetch port (IF) and the data port (MEM) onto the driver's single request interface (ce/we/addr/data/sel in, ready/data out).
- Latches the granted request and holds it stable until the driver reports ready, then returns the result to the requester.
- Forces one idle cycle between transactions, because the driver only clears its internal sequencer while its chip-enable is low. Also generates the pipeline stall request.

Parameters:
- TIMEOUT_CYCLES, 16: maximum BUSY cycles before abort. Used only with MEMARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- if_ce_i  in  1  instruction fetch request
- if_addr_i  in  32  fetch byte address
- if_data_o  out  32  fetched word
- if_ready_o  out  1  one-cycle fetch-complete pulse
- mem_ce_i  in  1  data access request
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  32  data byte address
- mem_data_i  in  32  write data
- mem_sel_i  in  4  byte enables
- mem_data_o  out  32  read data
- mem_ready_o  out  1  one-cycle data-complete pulse
- ram_ce_o  out  1  to driver chip enable (1 = enabled)
- ram_we_o  out  1  to driver write flag
- ram_addr_o  out  32  to driver address
- ram_data_o  out  32  to driver write data
- ram_sel_o  out  4  to driver byte enables
- ram_ready_i  in  1  from driver ready
- ram_data_i  in  32  from driver read data
- stall_req_o  out  1  pipeline stall request
- bus_err_o  out  1  timeout abort pulse (0 when feature off)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All registered outputs 0: ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o, if_data_o, mem_data_o, if_ready_o, mem_ready_o, bus_err_o.
- States: IDLE, IF_BUSY, MEM_BUSY, GAP.
- IDLE:
  - ram_ce_o=0.
  - mem_ce_i=1: latch mem_we_i/addr/data/sel, go to MEM_BUSY.
  - else if_ce_i=1: latch if_addr_i with we=0 and sel=4'b1111, go to IF_BUSY.
  - else stay in IDLE.
  - Simultaneous requests: MEM always wins; IF is served on the next IDLE.
- IF_BUSY / MEM_BUSY:
  - ram_ce_o=1.
  - ram_we_o/addr/data/sel driven from the latch. They must not change until the state exits, even if requester inputs change.
  - When ram_ready_i=1 is sampled: ram_data_i is registered into the owner's data_o (zeroed for writes), the owner's ready_o is set for the next cycle only, and the state goes to GAP.
- GAP:
  - ram_ce_o=0 for exactly one cycle; the owner's ready_o=1 in this cycle.
  - Next state is IDLE. New requests are sampled only in IDLE, so the pipeline advances during GAP and presents its next request.
- Latency:
  - ready_o rises exactly one cycle after ram_ready_i is sampled high.
  - The request is seen in IDLE at cycle N; ram_ce_o is high from N+1.
  - With a driver needing L enabled cycles, ready_o is high at cycle N+1+L.
- Data hold: if_data_o and mem_data_o hold their value until the next completion on that port.
- stall_req_o (combinational) = (mem_ce_i & ~mem_ready_o) | (if_ce_i & ~if_ready_o).
- Requester drops ce while BUSY: the transaction still runs to completion and ready still pulses. An SRAM write is never aborted.
- ram_ready_i high in IDLE or GAP: ignored.
- Reset mid-transaction: immediate return to IDLE with ram_ce_o=0, so the driver resets its own sequencer. No ready pulse is produced.

Optional Feature:
- Macro: MEMARB_TIMEOUT_EN.
- Defined:
  - A BUSY-cycle counter clears on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES without ram_ready_i, the state goes to GAP.
  - The owner's ready_o pulses with data_o=32'h0, and bus_err_o pulses in the same cycle.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - bus_err_o is tied to 0.

Test Plan:
- Fetch only: if_ce_i=1, if_addr_i=32'h0000_0010, model returns 32'hDEAD_BEEF after L=2 -> ram_ce_o high for 2 cycles, if_ready_o one-cycle pulse at N+3 with if_data_o=32'hDEAD_BEEF, ram_ce_o=0 in that cycle.
- Simultaneous requests: if_ce_i=1 and mem_ce_i=1 (read 32'h0040_0000), both L=2 -> mem_ready_o at N+3, GAP, IF granted at N+4, if_ready_o at N+7; stall_req_o=1 throughout until N+7.
- Partial write: mem_we_i=1, sel=4'b0010, data=32'h0000_AB00, L=3 -> ram_we_o=1 and ram_sel_o=4'b0010 held stable for 3 cycles, mem_ready_o at N+4, mem_data_o=0.
- Requester changes mem_addr_i mid-BUSY -> ram_addr_o stays at the latched value until GAP.
- Reset asserted during MEM_BUSY -> ram_ce_o=0 and all ready outputs 0 immediately; after release, a fresh fetch completes normally.
- MEMARB_TIMEOUT_EN defined with TIMEOUT_CYCLES=16, model never readies -> at BUSY cycle 16 the state goes to GAP; mem_ready_o=1, bus_err_o=1, mem_data_o=0 in that cycle.
